// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and butterfly-span helpers for the Kyber NTT sequencer.
package ntt_pkg;

    localparam int N      = 256;
    localparam int STAGES = 7;
    localparam int Q      = 3329;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } ntt_state_t;

    // log2 of the butterfly span: forward shrinks 128..2, inverse grows 2..128.
    function automatic logic [2:0] ntt_lg(input logic [2:0] stage, input logic inv);
        return inv ? stage + 3'd1 : 3'd7 - stage;
    endfunction

    function automatic logic [7:0] ntt_len(input logic [2:0] stage, input logic inv);
        return 8'd1 << ntt_lg(stage, inv);
    endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Fixed-latency valid/address delay line that lines write-back up with the butterfly pipe.
module ntt_wb_delay #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         vld_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         vld_o,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     a_q [DEPTH];
    logic [W-1:0]     b_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= vld_i;
            a_q[0]   <= a_i;
            b_q[0]   <= b_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                a_q[i]   <= a_q[i-1];
                b_q[i]   <= b_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign a_o   = a_q[DEPTH-1];
    assign b_o   = b_q[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// Kyber 256-point in-place NTT butterfly sequencer with write-back delay and stage drain.
// Inverse transform support is compiled in only when NTT_CTRL_INTT_EN is defined.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int PIPE_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              inv,
    input  logic              bf_ready,
    output logic              busy,
    output logic              done,
    output logic [2:0]        stage,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [6:0]        tw_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b
);

    localparam logic [3:0] DRAIN_LAST = 4'(PIPE_DEPTH - 1);
    localparam logic [2:0] LAST_STAGE = 3'(STAGES - 1);
    localparam logic [6:0] LAST_BF    = 7'(N / 2 - 1);

    ntt_state_t  state_q;
    logic [2:0]  stage_q;
    logic [6:0]  bf_cnt_q;
    logic [3:0]  drain_cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        eff_inv;
    logic [6:0]  tw_c;

    logic [2:0]        lg;
    logic [6:0]        grp7;
    logic [ADDR_W-1:0] cnt_w;
    logic [ADDR_W-1:0] len_w;
    logic [ADDR_W-1:0] grp_w;
    logic [ADDR_W-1:0] addr_a;
    logic              run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            bf_cnt_q    <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        stage_q  <= '0;
                        bf_cnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (bf_ready) begin
                        bf_cnt_q <= bf_cnt_q + 7'd1;
                        if (bf_cnt_q == LAST_BF) begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        if (stage_q == LAST_STAGE) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            stage_q  <= stage_q + 3'd1;
                            bf_cnt_q <= '0;
                            state_q  <= RUN;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lg    = ntt_lg(stage_q, eff_inv);
    assign grp7  = bf_cnt_q >> lg;
    assign cnt_w = ADDR_W'(bf_cnt_q);
    assign len_w = ADDR_W'(ntt_len(stage_q, eff_inv));
    assign grp_w = ADDR_W'(grp7);

    // Group base is 2*len*g; the offset fits below len so OR equals add.
    assign addr_a = ((grp_w << lg) << 1) | (cnt_w & (len_w - 1'b1));

`ifdef NTT_CTRL_INTT_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            inv_q <= inv;
        end
    end

    assign eff_inv = inv_q;
    assign tw_c    = inv_q ? (7'd127 >> stage_q) - grp7
                           : (7'd1 << stage_q) + grp7;
`else
    logic unused_inv;

    assign unused_inv = inv;
    assign eff_inv    = 1'b0;
    assign tw_c       = (7'd1 << stage_q) + grp7;
`endif

    assign run       = (state_q == RUN);
    assign rd_en     = run & bf_ready;
    assign rd_addr_a = run ? addr_a : '0;
    assign rd_addr_b = run ? addr_a + len_w : '0;
    assign tw_idx    = run ? tw_c : '0;

    assign busy  = busy_q;
    assign done  = done_q;
    assign stage = stage_q;

    ntt_wb_delay #(
        .DEPTH (PIPE_DEPTH),
        .W     (ADDR_W)
    ) u_wb_delay (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .vld_i  (rd_en),
        .a_i    (rd_addr_a),
        .b_i    (rd_addr_b),
        .vld_o  (wr_en),
        .a_o    (wr_addr_a),
        .b_o    (wr_addr_b)
    );

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: read-address model, write-back scoreboard, stalls, reset abort.
module tb_ntt_ctrl;

    localparam int PD = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          inv;
    logic          bf_ready;
    logic          busy;
    logic          done;
    logic [2:0]    stage;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [6:0]    tw_idx;
    logic          wr_en;
    logic [AW-1:0] wr_addr_a;
    logic [AW-1:0] wr_addr_b;

    ntt_ctrl #(
        .PIPE_DEPTH (PD),
        .ADDR_W     (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .inv       (inv),
        .bf_ready  (bf_ready),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int a;
        int b;
    } exp_t;

    exp_t sb[$];
    int   vec = 0;
    int   miss = 0;
    int   cyc = 0;
    int   iss = 0;
    int   wr_cnt = 0;
    bit   inv_m = 1'b0;

    int   s_m, i_m, len_m, g_m, ea, eb, et;
    exp_t e;
    int   n0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic spot(input string tag, input int a, input int b, input int t);
        check({tag, "_a"}, 32'(rd_addr_a), a);
        check({tag, "_b"}, 32'(rd_addr_b), b);
        check({tag, "_tw"}, 32'(tw_idx), t);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reads are checked against the closed-form decode, then queued for write-back.
    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            s_m   = iss / 128;
            i_m   = iss % 128;
            len_m = inv_m ? (2 << s_m) : (128 >> s_m);
            g_m   = i_m / len_m;
            ea    = 2 * len_m * g_m + i_m % len_m;
            eb    = ea + len_m;
            et    = inv_m ? (128 >> s_m) - 1 - g_m : (1 << s_m) + g_m;
            check("rd_stage", 32'(stage), s_m);
            check("rd_addr_a", 32'(rd_addr_a), ea);
            check("rd_addr_b", 32'(rd_addr_b), eb);
            check("rd_tw_idx", 32'(tw_idx), et);
            if (i_m == 0 && s_m > 0)
                check("hazard_wr_before_rd", wr_cnt, 128 * s_m);
            if (!inv_m) begin
                if (s_m == 0 && i_m == 5)   spot("fw_s0_bf5", 5, 133, 1);
                if (s_m == 1 && i_m == 70)  spot("fw_s1_bf70", 134, 198, 3);
                if (s_m == 6 && i_m == 127) spot("fw_s6_bf127", 253, 255, 127);
            end else begin
                if (s_m == 0 && i_m == 0)   spot("inv_s0_bf0", 0, 2, 127);
                if (s_m == 6 && i_m == 127) spot("inv_s6_bf127", 127, 255, 1);
            end
            sb.push_back('{cyc + PD, ea, eb});
            iss++;
        end
        if (wr_en === 1'b1) begin
            check("wr_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr_a", 32'(wr_addr_a), e.a);
                check("wr_addr_b", 32'(wr_addr_b), e.b);
            end
            wr_cnt++;
        end
    end

    task automatic run_xfrm(input bit inv_v, input bit stall, input bit chk_lat);
        int n;
        int ph;
        n      = 0;
        ph     = 0;
        iss    = 0;
        wr_cnt = 0;
        inv    = inv_v;
`ifdef NTT_CTRL_INTT_EN
        inv_m = inv_v;
`else
        inv_m = 1'b0;
`endif
        bf_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 1);
        for (int k = 0; k < 5000; k++) begin
            if (stall) bf_ready = (ph % 4 == 0) || (ph % 4 == 3);
            ph++;
            @(posedge clk); #1;
            n++;
            start = (n == 10);
            if (done === 1'b1) break;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 1);
        if (chk_lat) check("done_latency", n, 7 * (128 + PD));
        bf_ready = 1'b1;
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 0);
        check("busy_after_done", 32'(busy), 0);
        repeat (8) @(posedge clk);
        #1;
        check("idle_after_done", 32'(busy), 0);
        check("total_issues", iss, 896);
        check("total_writes", wr_cnt, 896);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        inv      = 1'b0;
        bf_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_stage", 32'(stage), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_rd_a", 32'(rd_addr_a), 0);
        check("rst_rd_b", 32'(rd_addr_b), 0);
        check("rst_tw", 32'(tw_idx), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_a", 32'(wr_addr_a), 0);
        check("rst_wr_b", 32'(wr_addr_b), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_xfrm(1'b0, 1'b0, 1'b1);

        run_xfrm(1'b0, 1'b1, 1'b0);

        iss      = 0;
        wr_cnt   = 0;
        inv      = 1'b0;
        inv_m    = 1'b0;
        bf_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (iss == 3 * 128 + 40) break;
            @(posedge clk); #1;
        end
        check("abort_reached", iss, 3 * 128 + 40);
        check("abort_stage", 32'(stage), 3);
        rst_n    = 1'b0;
        bf_ready = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        n0       = wr_cnt;
        bf_ready = 1'b1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_stage0", 32'(stage), 0);
        check("abort_rd_en", 32'(rd_en), 0);
        check("abort_rd_a", 32'(rd_addr_a), 0);
        check("abort_rd_b", 32'(rd_addr_b), 0);
        check("abort_tw", 32'(tw_idx), 0);
        check("abort_wr_en", 32'(wr_en), 0);
        check("abort_wr_a", 32'(wr_addr_a), 0);
        check("abort_wr_b", 32'(wr_addr_b), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_wr", wr_cnt, n0);
        check("abort_idle", 32'(busy), 0);

        run_xfrm(1'b0, 1'b0, 1'b1);

        run_xfrm(1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/ntt_ctrl.md
Name: ntt_ctrl

Overview:
- Sequencer for the in-place 256-point Kyber NTT (q = 3329) butterfly datapath. The datapath uses LUT-based modular reduction.
- Per butterfly issue it generates the coefficient-RAM read addresses, the twiddle ROM index and the issue strobe.
- It generates matching write-back addresses delayed by the butterfly pipeline depth.
- It inserts drain cycles between stages so the next stage never reads a coefficient that is still in flight.

Parameters:
- PIPE_DEPTH, 4, butterfly datapath latency in cycles from read issue to write-back; legal range 1..15.
- ADDR_W, 8, coefficient RAM address width (log2 of N = 256).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a transform; sampled only in IDLE
- inv  in  1  transform direction, 0 = forward NTT, 1 = inverse NTT; latched when start is accepted
- bf_ready  in  1  datapath can accept a butterfly this cycle
- busy  out  1  high from start acceptance until DONE exits
- done  out  1  one-cycle pulse at completion
- stage  out  3  current stage 0..6
- rd_en  out  1  butterfly issued this cycle
- rd_addr_a  out  ADDR_W  read address of the upper butterfly operand
- rd_addr_b  out  ADDR_W  read address of the lower butterfly operand
- tw_idx  out  7  twiddle (zeta) ROM index
- wr_en  out  1  write-back strobe
- wr_addr_a  out  ADDR_W  write-back address of the upper operand
- wr_addr_b  out  ADDR_W  write-back address of the lower operand

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
  - While rst_n = 0: state goes to IDLE; all counters and the delay line clear.
  - Reset values: every output is 0, including stage, all addresses and tw_idx.
  - Reset mid-transform aborts immediately. No write-back strobes are issued afterwards.
- State machine: IDLE, RUN, DRAIN, DONE.
  - IDLE: when start = 1, latch inv, clear stage and bf_cnt, go to RUN. busy = 1 from the next cycle.
  - RUN: rd_en = bf_ready. This is the only input-to-output combinational path; all other rd_* outputs are decoded from registers.
    - Each cycle with rd_en = 1, bf_cnt (7 bits) increments.
    - On the issue with bf_cnt = 127, go to DRAIN with drain_cnt = 0.
    - bf_ready = 0 holds all counters.
  - DRAIN: exactly PIPE_DEPTH cycles, rd_en = 0.
    - Afterwards, if stage = 6 go to DONE; otherwise stage++, bf_cnt = 0, back to RUN.
  - DONE: done = 1 for one cycle, busy stays high, then IDLE.
- start is ignored outside IDLE.
- Address decode, with len = 128 >> stage (forward) or 2 << stage (inverse), g = bf_cnt / len, o = bf_cnt mod len:
  - rd_addr_a = 2*len*g + o
  - rd_addr_b = rd_addr_a + len
  - Forward tw_idx = (1 << stage) + g
  - Inverse tw_idx = (128 >> stage) - 1 - g
- Write-back path:
  - {rd_en, rd_addr_a, rd_addr_b} passes through a PIPE_DEPTH-stage shift register that advances every cycle, bubbles included.
  - The shift register drives wr_en, wr_addr_a and wr_addr_b.
  - The delay line keeps running in DRAIN and DONE.
- Timing with bf_ready held at 1:
  - Each stage takes 128 + PIPE_DEPTH cycles.
  - done is high 7*(128+PIPE_DEPTH) cycles after the start-accept edge.
  - The last wr_en occurs in the final DRAIN cycle.

Optional Feature:
- Macro: NTT_CTRL_INTT_EN.
- Defined: inverse mode is supported as described above.
- Undefined:
  - The inv input is present but ignored; the block is forward-only.
  - The inverse address and twiddle logic is not synthesised.

Decomposition:
- Shared package ntt_pkg holds:
  - constants N = 256, STAGES = 7, Q = 3329;
  - ntt_state_t enum {IDLE, RUN, DRAIN, DONE};
  - a function computing len from stage and direction.
- One sub-module, ntt_wb_delay: the parameterised PIPE_DEPTH valid/address delay line with synchronous active-low clear.
- Address decode stays inline in ntt_ctrl.

Test Plan:
- Forward, bf_ready = 1, PIPE_DEPTH = 4:
  - stage 0, bf_cnt 5 -> addr 5/133, tw 1;
  - stage 1, bf_cnt 70 -> addr 134/198, tw 3;
  - stage 6, bf_cnt 127 -> addr 253/255, tw 127;
  - done 924 cycles after start.
- Inverse, with NTT_CTRL_INTT_EN defined:
  - stage 0, bf_cnt 0 -> addr 0/2, tw 127;
  - stage 6, bf_cnt 127 -> addr 127/255, tw 1.
- Write-back check: every rd_en with addresses (a, b) produces wr_en with (a, b) exactly 4 cycles later. Per stage, 128 write strobes and no others.
- bf_ready stall pattern 1,0,0,1 throughout:
  - addresses still cover each pair once per stage;
  - no rd_en during DRAIN;
  - total issues = 896.
- Hazard and start handling:
  - The first read of stage s+1 comes after the last wr_en of stage s.
  - start pulsed during RUN is ignored.
- Reset and build variant:
  - rst_n low at stage 3, bf_cnt 40 -> next cycle all outputs 0, no wr_en afterwards.
  - A fresh start then completes normally.
  - Build without the macro and inv = 1 -> forward addresses produced.
